// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall/flush controller:
// FSM state encodings and default stage indices.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        PC_RUN     = 1'b0,
        PC_MC_WAIT = 1'b1
    } pc_state_e;

    localparam int DEF_NSTAGE  = 5;
    localparam int DEF_LU_IDX  = 1;
    localparam int DEF_EX_IDX  = 2;
    localparam int DEF_MEM_IDX = 3;

endpackage

// File: rtl/pipe_ctrl_stall_vec_gen.sv
// Builds the hold/flush vector pair for a stall at register STALL_IDX:
// registers 0..STALL_IDX hold, register STALL_IDX+1 receives a bubble.
module stall_vec_gen #(
    parameter int NSTAGE    = 5,
    parameter int STALL_IDX = 1
) (
    input  logic              i_en,
    output logic [NSTAGE-1:0] o_hold,
    output logic [NSTAGE-1:0] o_flush
);

    localparam logic [NSTAGE-1:0] HOLD_MASK  = {NSTAGE{1'b1}} >> (NSTAGE - 1 - STALL_IDX);
    localparam logic [NSTAGE-1:0] FLUSH_MASK = NSTAGE'(1) << (STALL_IDX + 1);

    assign o_hold  = i_en ? HOLD_MASK  : '0;
    assign o_flush = i_en ? FLUSH_MASK : '0;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: priority-muxes dmem back-pressure, multi-cycle
// EX waits, mispredict redirects and load-use stalls into hold/flush vectors.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE     = DEF_NSTAGE,
    parameter int LU_IDX     = DEF_LU_IDX,
    parameter int EX_IDX     = DEF_EX_IDX,
    parameter int MEM_IDX    = DEF_MEM_IDX,
    parameter int ADDR_W     = 32,
    parameter int REG_AW     = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_rs1_read_i,
    input  logic              id_rs2_read_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              id_ex_load_i,
    input  logic [REG_AW-1:0] id_ex_rd_addr_i,
    input  logic              ex_valid_i,
    input  logic [ADDR_W-1:0] ex_instaddr_i,
    input  logic              ex_prd_taken_i,
    input  logic [ADDR_W-1:0] ex_prd_target_i,
    input  logic              ex_jump_en_i,
    input  logic [ADDR_W-1:0] ex_jump_base_i,
    input  logic [ADDR_W-1:0] ex_jump_ofst_i,
    input  logic              ex_hold_req_i,
    input  logic              ex_hold_done_i,
    input  logic              dmem_busy_i,
    output logic [NSTAGE-1:0] hold_en_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic              redirect_en_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              mc_timeout_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  redir_cnt_o
);

    generate
        if (NSTAGE <= MEM_IDX + 1) begin : g_bad_nstage
            $error("pipe_ctrl: NSTAGE must exceed MEM_IDX+1");
        end
        if (!(MEM_IDX > EX_IDX && EX_IDX > LU_IDX && LU_IDX >= 0)) begin : g_bad_idx
            $error("pipe_ctrl: need MEM_IDX > EX_IDX > LU_IDX >= 0");
        end
    endgenerate

    localparam int WD_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [NSTAGE-1:0] MP_FLUSH_MASK =
        ({NSTAGE{1'b1}} >> (NSTAGE - 1 - EX_IDX)) & ~NSTAGE'(1);

    pc_state_e r_state;
    pc_state_e w_state_nxt;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_redir_cnt;

    logic              w_mem_en;
    logic              w_ex_en;
    logic              w_lu_en;
    logic              w_mispred;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_jump_target;
    logic [NSTAGE-1:0] w_mem_hold, w_mem_flush;
    logic [NSTAGE-1:0] w_ex_hold, w_ex_flush;
    logic [NSTAGE-1:0] w_lu_hold, w_lu_flush;
    logic [NSTAGE-1:0] w_hold, w_flush;
    logic              w_redir_en;
    logic [ADDR_W-1:0] w_redir_pc;

    assign w_mem_en = dmem_busy_i;
    assign w_ex_en  = !ex_hold_done_i &&
                      ((r_state == PC_RUN && ex_hold_req_i) || r_state == PC_MC_WAIT);
    assign w_lu_en  = id_ex_load_i && (id_ex_rd_addr_i != '0) &&
                      ((id_rs1_read_i && id_rs1_addr_i == id_ex_rd_addr_i) ||
                       (id_rs2_read_i && id_rs2_addr_i == id_ex_rd_addr_i));

    assign w_jump_target = ex_jump_base_i + ex_jump_ofst_i;
    assign w_mispred     = (ex_jump_en_i != ex_prd_taken_i) ||
                           (ex_jump_en_i && ex_prd_taken_i && ex_prd_target_i != w_jump_target);
    // While waiting without done, w_ex_en is set, so this covers RUN and the done cycle only.
    assign w_redirect    = ex_valid_i && !w_mem_en && !w_ex_en && w_mispred;

    stall_vec_gen #(.NSTAGE(NSTAGE), .STALL_IDX(MEM_IDX)) u_mem_vec (
        .i_en(w_mem_en), .o_hold(w_mem_hold), .o_flush(w_mem_flush)
    );
    stall_vec_gen #(.NSTAGE(NSTAGE), .STALL_IDX(EX_IDX)) u_ex_vec (
        .i_en(w_ex_en), .o_hold(w_ex_hold), .o_flush(w_ex_flush)
    );
    stall_vec_gen #(.NSTAGE(NSTAGE), .STALL_IDX(LU_IDX)) u_lu_vec (
        .i_en(w_lu_en), .o_hold(w_lu_hold), .o_flush(w_lu_flush)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PC_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold      = '0;
        w_flush     = '0;
        w_redir_en  = 1'b0;
        w_redir_pc  = '0;

        if (!dmem_busy_i) begin
            case (r_state)
                PC_RUN:     if (ex_hold_req_i && ex_valid_i && !ex_hold_done_i) w_state_nxt = PC_MC_WAIT;
                PC_MC_WAIT: if (ex_hold_done_i) w_state_nxt = PC_RUN;
                default:    w_state_nxt = PC_RUN;
            endcase
        end

        if (w_mem_en) begin
            w_hold  = w_mem_hold;
            w_flush = w_mem_flush;
        end else if (w_ex_en) begin
            w_hold  = w_ex_hold;
            w_flush = w_ex_flush;
        end else if (w_redirect) begin
            w_flush    = MP_FLUSH_MASK;
            w_redir_en = 1'b1;
            w_redir_pc = ex_jump_en_i ? w_jump_target : (ex_instaddr_i + ADDR_W'(4));
        end else if (w_lu_en) begin
            w_hold  = w_lu_hold;
            w_flush = w_lu_flush;
        end
    end

    // Watchdog counts MC_WAIT cycles, freezes under dmem back-pressure, flags sticky timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (!dmem_busy_i) begin
            if (r_state == PC_MC_WAIT && !ex_hold_done_i) begin
                if (r_wd_cnt != WD_W'(MC_TIMEOUT)) begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                end
                if (r_wd_cnt == WD_W'(MC_TIMEOUT - 1)) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (w_hold[0] && r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redir_en && r_redir_cnt != {CNT_W{1'b1}}) begin
                r_redir_cnt <= r_redir_cnt + 1'b1;
            end
        end
    end

    assign hold_en_o     = w_hold;
    assign flush_o       = w_flush;
    assign redirect_en_o = w_redir_en;
    assign redirect_pc_o = w_redir_pc;
    assign mc_timeout_o  = r_timeout;
    assign stall_cnt_o   = r_stall_cnt;
    assign redir_cnt_o   = r_redir_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_rs1_read_i, id_rs2_read_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
    logic        id_ex_load_i;
    logic [4:0]  id_ex_rd_addr_i;
    logic        ex_valid_i;
    logic [31:0] ex_instaddr_i;
    logic        ex_prd_taken_i;
    logic [31:0] ex_prd_target_i;
    logic        ex_jump_en_i;
    logic [31:0] ex_jump_base_i, ex_jump_ofst_i;
    logic        ex_hold_req_i, ex_hold_done_i;
    logic        dmem_busy_i;
    logic [4:0]  hold_en_o, flush_o;
    logic        redirect_en_o;
    logic [31:0] redirect_pc_o;
    logic        mc_timeout_o;
    logic [31:0] stall_cnt_o, redir_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1_read_i(id_rs1_read_i), .id_rs2_read_i(id_rs2_read_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_ex_load_i(id_ex_load_i), .id_ex_rd_addr_i(id_ex_rd_addr_i),
        .ex_valid_i(ex_valid_i), .ex_instaddr_i(ex_instaddr_i),
        .ex_prd_taken_i(ex_prd_taken_i), .ex_prd_target_i(ex_prd_target_i),
        .ex_jump_en_i(ex_jump_en_i), .ex_jump_base_i(ex_jump_base_i),
        .ex_jump_ofst_i(ex_jump_ofst_i), .ex_hold_req_i(ex_hold_req_i),
        .ex_hold_done_i(ex_hold_done_i), .dmem_busy_i(dmem_busy_i),
        .hold_en_o(hold_en_o), .flush_o(flush_o),
        .redirect_en_o(redirect_en_o), .redirect_pc_o(redirect_pc_o),
        .mc_timeout_o(mc_timeout_o), .stall_cnt_o(stall_cnt_o),
        .redir_cnt_o(redir_cnt_o)
    );

    task automatic idle();
        id_rs1_read_i = 0; id_rs2_read_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        id_ex_load_i = 0; id_ex_rd_addr_i = 0; ex_valid_i = 0; ex_instaddr_i = 0;
        ex_prd_taken_i = 0; ex_prd_target_i = 0; ex_jump_en_i = 0;
        ex_jump_base_i = 0; ex_jump_ofst_i = 0; ex_hold_req_i = 0;
        ex_hold_done_i = 0; dmem_busy_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #3;
        checks++;
        if ({hold_en_o, flush_o, redirect_en_o, mc_timeout_o} !== 12'b0 || redirect_pc_o !== 32'h0 ||
            stall_cnt_o !== 32'h0 || redir_cnt_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset: hold=%b flush=%b redir=%b pc=%h to=%b sc=%0d rc=%0d, want all 0",
                     hold_en_o, flush_o, redirect_en_o, redirect_pc_o, mc_timeout_o, stall_cnt_o, redir_cnt_o);
        end
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        id_ex_load_i = 1; id_ex_rd_addr_i = 5; id_rs1_read_i = 1; id_rs1_addr_i = 5;
        #1;
        checks++;
        if (hold_en_o !== 5'b00011 || flush_o !== 5'b00100 || redirect_en_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lu_rs1: hold=%b flush=%b redir=%b, want 00011 00100 0", hold_en_o, flush_o, redirect_en_o);
        end
        step();
        id_ex_rd_addr_i = 0; id_rs1_addr_i = 0;
        #1;
        checks++;
        if (hold_en_o !== 5'b0 || flush_o !== 5'b0) begin
            errors++;
            $display("[TB] FAIL lu_rd0: hold=%b flush=%b, want 00000 00000", hold_en_o, flush_o);
        end
        step();
        id_rs1_read_i = 0; id_rs1_addr_i = 7; id_rs2_read_i = 1; id_rs2_addr_i = 7; id_ex_rd_addr_i = 7;
        #1;
        checks++;
        if (hold_en_o !== 5'b00011 || flush_o !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL lu_rs2: hold=%b flush=%b, want 00011 00100", hold_en_o, flush_o);
        end
        step();
        idle();
        #1;
        checks++;
        if (stall_cnt_o !== 32'd2 || hold_en_o !== 5'b0) begin
            errors++;
            $display("[TB] FAIL lu_cnt: stall_cnt=%0d hold=%b, want 2 00000", stall_cnt_o, hold_en_o);
        end
    endtask

    task automatic test_multi_cycle();
        int bad = 0;
        do_reset();
        ex_valid_i = 1; ex_hold_req_i = 1;
        #1;
        checks++;
        if (hold_en_o !== 5'b00111 || flush_o !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL mc_start: hold=%b flush=%b, want 00111 01000", hold_en_o, flush_o);
        end
        step();
        ex_hold_req_i = 0;
        for (int i = 1; i < 10; i++) begin
            #1;
            if (hold_en_o !== 5'b00111 || flush_o !== 5'b01000) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL mc_wait: %0d of 9 wait cycles wrong, want 0", bad);
        end
        ex_hold_done_i = 1;
        #1;
        checks++;
        if (hold_en_o !== 5'b0 || flush_o !== 5'b0 || redirect_en_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mc_done: hold=%b flush=%b redir=%b, want 00000 00000 0", hold_en_o, flush_o, redirect_en_o);
        end
        step();
        ex_hold_done_i = 0; ex_valid_i = 0;
        #1;
        checks++;
        if (stall_cnt_o !== 32'd10 || hold_en_o !== 5'b0) begin
            errors++;
            $display("[TB] FAIL mc_cnt: stall_cnt=%0d hold=%b, want 10 00000", stall_cnt_o, hold_en_o);
        end
    endtask

    task automatic test_mispredict_taken();
        do_reset();
        ex_valid_i = 1; ex_prd_taken_i = 0; ex_jump_en_i = 1;
        ex_jump_base_i = 32'h100; ex_jump_ofst_i = 32'h20;
        #1;
        checks++;
        if (redirect_en_o !== 1'b1 || redirect_pc_o !== 32'h120 || flush_o !== 5'b00110 || hold_en_o !== 5'b0) begin
            errors++;
            $display("[TB] FAIL mp_taken: redir=%b pc=%h flush=%b hold=%b, want 1 00000120 00110 00000",
                     redirect_en_o, redirect_pc_o, flush_o, hold_en_o);
        end
        step();
        ex_prd_taken_i = 1; ex_prd_target_i = 32'h124;
        #1;
        checks++;
        if (redirect_en_o !== 1'b1 || redirect_pc_o !== 32'h120) begin
            errors++;
            $display("[TB] FAIL mp_target: redir=%b pc=%h, want 1 00000120", redirect_en_o, redirect_pc_o);
        end
        step();
        idle();
        #1;
        checks++;
        if (redir_cnt_o !== 32'd2 || redirect_en_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mp_cnt: redir_cnt=%0d redir=%b pc=%h, want 2 0 00000000", redir_cnt_o, redirect_en_o, redirect_pc_o);
        end
    endtask

    task automatic test_mispredict_not_taken();
        do_reset();
        ex_valid_i = 1; ex_prd_taken_i = 1; ex_prd_target_i = 32'h300; ex_jump_en_i = 0; ex_instaddr_i = 32'h200;
        #1;
        checks++;
        if (redirect_en_o !== 1'b1 || redirect_pc_o !== 32'h204 || flush_o !== 5'b00110) begin
            errors++;
            $display("[TB] FAIL mp_nt: redir=%b pc=%h flush=%b, want 1 00000204 00110", redirect_en_o, redirect_pc_o, flush_o);
        end
        step();
        ex_jump_en_i = 1; ex_jump_base_i = 32'h100; ex_jump_ofst_i = 32'h20; ex_prd_target_i = 32'h120;
        #1;
        checks++;
        if (redirect_en_o !== 1'b0 || redirect_pc_o !== 32'h0 || flush_o !== 5'b0) begin
            errors++;
            $display("[TB] FAIL mp_correct: redir=%b pc=%h flush=%b, want 0 00000000 00000", redirect_en_o, redirect_pc_o, flush_o);
        end
        step();
        ex_prd_taken_i = 0; ex_jump_base_i = 32'hFFFF_FFF0; ex_jump_ofst_i = 32'h20;
        id_ex_load_i = 1; id_ex_rd_addr_i = 3; id_rs1_read_i = 1; id_rs1_addr_i = 3;
        #1;
        checks++;
        if (redirect_pc_o !== 32'h10 || hold_en_o !== 5'b0 || flush_o !== 5'b00110) begin
            errors++;
            $display("[TB] FAIL mp_wrap_lu: pc=%h hold=%b flush=%b, want 00000010 00000 00110", redirect_pc_o, hold_en_o, flush_o);
        end
        step();
        idle();
    endtask

    task automatic test_priority();
        do_reset();
        dmem_busy_i = 1; ex_valid_i = 1; ex_prd_taken_i = 0; ex_jump_en_i = 1;
        ex_jump_base_i = 32'h100; ex_jump_ofst_i = 32'h20;
        id_ex_load_i = 1; id_ex_rd_addr_i = 5; id_rs1_read_i = 1; id_rs1_addr_i = 5;
        #1;
        checks++;
        if (hold_en_o !== 5'b01111 || flush_o !== 5'b10000 || redirect_en_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_busy: hold=%b flush=%b redir=%b, want 01111 10000 0", hold_en_o, flush_o, redirect_en_o);
        end
        step();
        dmem_busy_i = 0;
        #1;
        checks++;
        if (redirect_en_o !== 1'b1 || redirect_pc_o !== 32'h120 || hold_en_o !== 5'b0 || flush_o !== 5'b00110) begin
            errors++;
            $display("[TB] FAIL prio_release: redir=%b pc=%h hold=%b flush=%b, want 1 00000120 00000 00110",
                     redirect_en_o, redirect_pc_o, hold_en_o, flush_o);
        end
        step();
        ex_hold_req_i = 1; id_ex_load_i = 0;
        #1;
        checks++;
        if (redirect_en_o !== 1'b0 || hold_en_o !== 5'b00111 || flush_o !== 5'b01000) begin
            errors++;
            $display("[TB] FAIL prio_ex: redir=%b hold=%b flush=%b, want 0 00111 01000", redirect_en_o, hold_en_o, flush_o);
        end
        ex_hold_req_i = 0; ex_hold_done_i = 1;
        #1;
        checks++;
        if (stall_cnt_o !== 32'd1 || redir_cnt_o !== 32'd1) begin
            errors++;
            $display("[TB] FAIL prio_cnt: stall_cnt=%0d redir_cnt=%0d, want 1 1", stall_cnt_o, redir_cnt_o);
        end
        step();
        idle();
    endtask

    task automatic test_watchdog();
        int bad = 0;
        do_reset();
        ex_valid_i = 1; ex_hold_req_i = 1;
        step();
        idle();
        for (int i = 0; i < 63; i++) begin
            step();
            if (mc_timeout_o !== 1'b0 || hold_en_o !== 5'b00111) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL wd_early: %0d of 63 cycles wrong before timeout, want 0", bad);
        end
        step();
        checks++;
        if (mc_timeout_o !== 1'b1 || hold_en_o !== 5'b00111) begin
            errors++;
            $display("[TB] FAIL wd_fire: timeout=%b hold=%b, want 1 00111", mc_timeout_o, hold_en_o);
        end
        ex_hold_done_i = 1;
        step();
        ex_hold_done_i = 0;
        #1;
        checks++;
        if (mc_timeout_o !== 1'b1 || hold_en_o !== 5'b0) begin
            errors++;
            $display("[TB] FAIL wd_sticky: timeout=%b hold=%b, want 1 00000", mc_timeout_o, hold_en_o);
        end
        ex_valid_i = 1; ex_hold_req_i = 1;
        step();
        idle();
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (hold_en_o !== 5'b0 || flush_o !== 5'b0 || redirect_en_o !== 1'b0 || mc_timeout_o !== 1'b0 ||
            stall_cnt_o !== 32'h0 || redir_cnt_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wd_reset: hold=%b flush=%b redir=%b to=%b sc=%0d rc=%0d, want all 0",
                     hold_en_o, flush_o, redirect_en_o, mc_timeout_o, stall_cnt_o, redir_cnt_o);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (hold_en_o !== 5'b0 || mc_timeout_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wd_run: hold=%b timeout=%b, want 00000 0", hold_en_o, mc_timeout_o);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #2;
        test_reset();
        test_load_use();
        test_multi_cycle();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_priority();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
